// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer.
//   load, load_val, start, stop, auto_reload : commands into the timer
//   count, tick, running, done                : timer status
// master drives commands and observes status; slave is the timer itself.
interface countdown_timer_if #(
    parameter int unsigned N = 8
);
    logic         load;
    logic [N-1:0] load_val;
    logic         start;
    logic         stop;
    logic         auto_reload;
    logic [N-1:0] count;
    logic         tick;
    logic         running;
    logic         done;

    modport master (
        output load, load_val, start, stop, auto_reload,
        input  count, tick, running, done
    );

    modport slave (
        input  load, load_val, start, stop, auto_reload,
        output count, tick, running, done
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with IDLE/RUN/PAUSE/DONE control and a one-cycle expiry tick.
// Ports:
//   clk  : system clock, all state on posedge
//   rst  : synchronous active-high reset
//   bus  : countdown_timer_if.slave (commands in, count/tick/running/done out)
// PRESCALE clk cycles make one decrement step while running; on expiry the
// count either reloads (auto_reload with nonzero reload value) or stops at 0.
module countdown_timer #(
    parameter int unsigned N        = 8,
    parameter int unsigned PRESCALE = 1
) (
    input  logic               clk,
    input  logic               rst,
    countdown_timer_if.slave   bus
);
    localparam int unsigned PW = $clog2(PRESCALE) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  count_q, count_d;
    logic [N-1:0]  reload_q, reload_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          running_q, done_q;

    // State and datapath registers; status flags are registered decodes of the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == DONE);
        end
    end

    // Next-state logic: load > stop > start > counting
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        tick_d   = 1'b0;

        if (bus.load) begin
            count_d  = bus.load_val;
            reload_d = bus.load_val;
            presc_d  = '0;
            state_d  = IDLE;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.stop) begin
                        state_d = PAUSE;
                    end else if (presc_q == PW'(PRESCALE - 1)) begin
                        presc_d = '0;
                        // count is never 0 in RUN, so "not > 1" means expiry
                        if (count_q > N'(1)) begin
                            count_d = count_q - N'(1);
                        end else begin
                            tick_d = 1'b1;
                            if (bus.auto_reload && (reload_q != '0)) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = DONE;
                            end
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: begin
                    if (bus.start && (count_q != '0)) begin
                        state_d = RUN;
                    end
                end
            endcase
        end
    end

    assign bus.count   = count_q;
    assign bus.tick    = tick_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;
endmodule
